priority_decoder_dispatch: RTL and testbench
============================================

Name: priority_decoder_dispatch

Overview:
- Other end of the 8-to-3 priority encoder: accepts an encoded request {code[2:0], idle} and turns it back into a one-hot grant on one of 8 lines.
- Holds the grant until the addressed line acknowledges, or until a timeout expires.
- Handshaked input, so an upstream encoder/arbiter stage can queue the next request.
- Sits between the interrupt/request encoder and the 8 serviced units.

Parameters:
- TIMEOUT, 15, max cycles a grant is held without ack; legal range 1..255.
- TW, $clog2(TIMEOUT+1), timer width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_code  in  3  encoded request index (7 = highest priority line).
- in_idle  in  1  1 = no request present; in_code ignored.
- in_valid  in  1  request word valid.
- in_ready  out  1  block can accept a request word this cycle.
- grant  out  8  one-hot grant; at most one bit set.
- ack  in  8  per-line acknowledge from serviced units.
- done  out  1  one-cycle pulse: grant acknowledged.
- timeout  out  1  one-cycle pulse: grant dropped without ack.
- last_code  out  3  code of the most recent grant (done or timeout).
- ack_err  out  1  one-cycle pulse: ack on a non-granted line.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; grant=0, done=0, timeout=0, ack_err=0, last_code=0, timer=0, busy=0.
  - in_ready reads 1 (combinational from IDLE); in_valid is ignored while rst_n is low.
- FSM states: IDLE, GRANT, RELEASE.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- A transfer occurs when in_valid && in_ready on a rising edge.
- IDLE:
  - Transfer with in_idle=1: word consumed, no grant, stay IDLE.
  - Transfer with in_idle=0: latch code into last_code, grant <= 1<<in_code, timer <= 0, go to GRANT.
  - Grant appears on the cycle after acceptance (latency 1).
- GRANT:
  - grant held stable; timer increments by 1 each cycle.
  - If ack[last_code]=1: grant <= 0, done pulse, go to RELEASE.
  - Else if timer==TIMEOUT-1: grant <= 0, timeout pulse, go to RELEASE.
  - If both happen on the same cycle, ack wins: done=1, timeout=0.
  - ack_err pulses on any cycle where (ack & ~grant)!=0, regardless of whether the granted line also acks that cycle.
  - Grant therefore lasts at most TIMEOUT cycles.
- RELEASE:
  - Single cycle: grant=0, in_ready=0, then go to IDLE.
  - Guarantees at least one grant-low cycle between consecutive grants.
  - Minimum request-to-request throughput is 3 cycles.
- IDLE and RELEASE: ack is ignored for done/timeout; ack_err still pulses if ack!=0.
- done, timeout and ack_err are registered pulses, exactly 1 cycle wide.
- Timer saturates logically: it never exceeds TIMEOUT-1 because the FSM leaves GRANT at that point.
- TIMEOUT=1: grant lasts exactly 1 cycle; an ack in that cycle gives done, otherwise timeout.
- Reset asserted mid-GRANT: grant drops immediately (async); no done or timeout pulse is produced.
- in_code X while in_idle=1 must not propagate to grant.

Test Plan:
- Reset then idle word: assert rst_n=0 → grant=0, busy=0. Release, send {code=5, idle=1, valid} → in_ready stays 1, grant stays 0.
- Basic grant/ack: send code=3 → grant=8'b0000_1000 the next cycle. ack[3]=1 two cycles later → done pulses 1 cycle, last_code=3, grant=0, in_ready=1 two cycles after the ack.
- Timeout: send code=7, never ack → grant=8'h80 for exactly 15 cycles, timeout pulses, done stays 0, last_code=7.
- Ack on the final cycle: send code=0, ack[0]=1 exactly on timer==14 → done=1, timeout=0.
- Wrong-line ack: grant=8'h04, drive ack=8'h10 → ack_err pulses, grant stays 8'h04. Then ack=8'h14 → done=1 and ack_err=1 on the same cycle.
- Back-to-back with mid-operation reset: hold valid with codes 6,1 → grants separated by ≥1 low cycle. Assert rst_n=0 during the second grant → grant=0 immediately, no done/timeout; after reset, accepts a new request.

Source files
------------

// File: rtl/priority_decoder_dispatch.sv
// priority_decoder_dispatch: turns an encoded request back into a one-hot grant held until ack or timeout
module priority_decoder_dispatch #(
  parameter int TIMEOUT = 15,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_code,
  input  logic       in_idle,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] grant,
  input  logic [7:0] ack,
  output logic       done,
  output logic       timeout,
  output logic [2:0] last_code,
  output logic       ack_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] grant_n;
  logic [2:0] last_code_n;
  logic done_n, timeout_n, hit, expire;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign hit = ack[last_code];
  assign expire = timer == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    grant_n = grant;
    timer_n = timer;
    last_code_n = last_code;
    done_n = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: if (in_valid && !in_idle) begin
        state_n = GRANT;
        grant_n = 8'(1) << in_code;
        timer_n = '0;
        last_code_n = in_code;
      end
      GRANT: if (hit || expire) begin
        state_n = RELEASE;
        grant_n = '0;
        done_n = hit;
        timeout_n = !hit;
      end else begin
        timer_n = timer + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      timer <= '0;
      last_code <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      timer <= timer_n;
      last_code <= last_code_n;
      done <= done_n;
      timeout <= timeout_n;
      ack_err <= |(ack & ~grant);
    end
  end
endmodule

// File: tb/tb_priority_decoder_dispatch.sv
// tb_priority_decoder_dispatch: vector table, corner-case sequences and randomized transactions vs a transaction-level model
module tb_priority_decoder_dispatch;
  localparam int T = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] in_code = '0, last_code;
  logic in_idle = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0] grant, ack = '0;
  logic done, timeout, ack_err, busy;
  int total = 0, passed = 0;
  priority_decoder_dispatch #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_idle(in_idle), .in_valid(in_valid),
    .in_ready(in_ready), .grant(grant), .ack(ack), .done(done), .timeout(timeout),
    .last_code(last_code), .ack_err(ack_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // One request from IDLE; the addressed line acks at grant cycle ack_at (never if >= T).
  task automatic txn(input logic [2:0] c, input int ack_at, input bit noise,
                     output int len, output bit d, output bit t);
    logic [7:0] a, g;
    g = 8'(1) << c;
    len = 0; d = 0; t = 0;
    in_valid = 1; in_idle = 0; in_code = c;
    step();
    in_valid = 0; in_code = 3'($urandom);
    for (int k = 0; k < 300; k++) begin
      chk("grant_held", grant, g);
      a = (k == ack_at) ? g : 8'h0;
      if (noise && $urandom_range(3) == 0) a |= 8'($urandom) & ~g;
      ack = a;
      step();
      ack = '0;
      chk("ack_err", ack_err, |(a & ~g));
      if (grant == 0) begin
        len = k + 1; d = done; t = timeout;
        break;
      end
      chk("no_early_pulse", {done, timeout}, 0);
    end
    if (len == 0) chk("txn_bound", 0, 1);
    chk("last_code", last_code, c);
    chk("release_ready", {in_ready, busy}, 2'b01);
    step();
    chk("idle_ready", {in_ready, busy, done, timeout}, 4'b1000);
  endtask
  typedef struct { logic [2:0] code; int ack_at; int len; bit d; bit t; } vec_t;
  vec_t vecs[7];
  int len;
  bit d, t;
  initial begin
    vecs[0] = '{3'd3, 2, 3, 1, 0};
    vecs[1] = '{3'd7, -1, 15, 0, 1};
    vecs[2] = '{3'd0, 14, 15, 1, 0};
    vecs[3] = '{3'd5, 0, 1, 1, 0};
    vecs[4] = '{3'd1, 13, 14, 1, 0};
    vecs[5] = '{3'd4, 20, 15, 0, 1};
    vecs[6] = '{3'd6, 7, 8, 1, 0};
    #3;
    chk("reset_outputs", {grant, busy, in_ready, done, timeout, ack_err, last_code}, {8'h0, 1'b0, 1'b1, 6'h0});
    step();
    rst_n = 1;
    in_valid = 1; in_idle = 1; in_code = 3'd5;
    step();
    in_valid = 0; in_idle = 0;
    chk("idle_word", {grant, in_ready, busy}, {8'h0, 2'b10});
    foreach (vecs[i]) begin
      txn(vecs[i].code, vecs[i].ack_at, 0, len, d, t);
      chk("vec_len", len, vecs[i].len);
      chk("vec_done_timeout", {d, t}, {vecs[i].d, vecs[i].t});
    end
    // wrong-line ack, then simultaneous right+wrong ack
    in_valid = 1; in_code = 3'd2;
    step();
    in_valid = 0;
    ack = 8'h10;
    step();
    ack = 0;
    chk("wrong_ack", {ack_err, done, grant}, {2'b10, 8'h04});
    step();
    chk("wrong_ack_pulse", {ack_err, grant}, {1'b0, 8'h04});
    ack = 8'h14;
    step();
    ack = 0;
    chk("both_ack", {ack_err, done, timeout, grant}, {3'b110, 8'h00});
    step();
    ack = 8'h01;
    step();
    ack = 0;
    chk("idle_ack_err", {ack_err, done, timeout, grant}, {3'b100, 8'h00});
    // back-to-back with valid held, then reset mid-grant
    in_valid = 1; in_code = 3'd6;
    step();
    chk("b2b_first", grant, 8'h40);
    ack = 8'h40;
    step();
    ack = 0; in_code = 3'd1;
    chk("b2b_done", {done, grant}, {1'b1, 8'h00});
    step();
    chk("b2b_gap", {grant, in_ready}, {8'h00, 1'b1});
    step();
    in_valid = 0;
    chk("b2b_second", grant, 8'h02);
    #2 rst_n = 0;
    #1 chk("async_reset", {grant, busy, in_ready}, {8'h00, 2'b01});
    step();
    chk("reset_no_pulse", {done, timeout, grant}, 10'h0);
    rst_n = 1;
    step();
    txn(3'd5, 3, 0, len, d, t);
    chk("post_reset_txn", {len, d, t}, {32'd4, 2'b10});
    // randomized transactions against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(4) == 0) begin
        in_valid = 1; in_idle = 1; in_code = 3'($urandom);
        step();
        in_valid = 0; in_idle = 0;
        chk("rand_idle_word", {grant, in_ready}, {8'h00, 1'b1});
      end else begin
        int at;
        logic [2:0] c;
        at = $urandom_range(20);
        c = 3'($urandom);
        txn(c, at, 1, len, d, t);
        chk("rand_len", len, (at < T) ? at + 1 : T);
        chk("rand_outcome", {d, t}, (at < T) ? 2'b10 : 2'b01);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
